multi_lane_deserializer: RTL and testbench

Parametrised successor to the single-lane fetch deserializer. Collects FETCH_WIDTH-bit words from LANES parallel serial inputs, with selectable bit order. Presents each completed word on a valid/ready output holding register, so a downstream consumer such as a weight/activation fetch FIFO can apply backpressure. Dropped words are flagged on a sticky overflow output.

---
 rtl/multi_lane_deserializer.sv | 83 ++++++++
 tb/tb_multi_lane_deserializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_deserializer.sv
// multi_lane_deserializer: collects LANES-wide serial beats into FETCH_WIDTH-bit words behind a valid/ready holding register; `define DESER_PARITY_EN adds a per-lane even-parity beat
module multi_lane_deserializer #(
  parameter int FETCH_WIDTH = 16,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       serial_data,
  input  logic                   en,
  input  logic                   msb_first,
  input  logic                   out_ready,
  input  logic                   ovf_clr,
  output logic [FETCH_WIDTH-1:0] parallel_data,
  output logic                   out_valid,
  output logic                   overflow,
  output logic                   parity_err
);
  localparam int BEATS = FETCH_WIDTH / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
`ifdef DESER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
`endif
  if (FETCH_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide FETCH_WIDTH");
  end
  logic [CNT_W-1:0] cnt;
  logic [FETCH_WIDTH-1:0] asm_q, asm_d, word;
  logic order_q, ord, done, load;
  assign ord = (cnt == '0) ? msb_first : order_q;
  assign done = en && cnt == LAST;
  assign load = done && (!out_valid || out_ready);
  for (genvar b = 0; b < FETCH_WIDTH; b++) begin : g_bit
    localparam int KL = b / LANES;
    localparam int LL = b % LANES;
    localparam int KM = (FETCH_WIDTH - 1 - b) / LANES;
    localparam int LM = (FETCH_WIDTH - 1 - b) % LANES;
    assign asm_d[b] = !en ? 1'b0 :
                      ord ? (cnt == CNT_W'(KM) ? serial_data[LM] : asm_q[b]) :
                            (cnt == CNT_W'(KL) ? serial_data[LL] : asm_q[b]);
  end
`ifdef DESER_PARITY_EN
  logic [LANES-1:0] par_q;
  logic perr;
  assign word = asm_q;
  assign perr = |(serial_data ^ par_q);
  // running per-lane parity of the data beats, restarted at beat 0
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= '0;
    else par_q <= (cnt == '0) ? serial_data : par_q ^ serial_data;
  // parity flag travels with the word in the holding register
  always_ff @(posedge clk or posedge rst)
    if (rst) parity_err <= 1'b0;
    else if (load) parity_err <= perr;
    else if (out_valid && out_ready) parity_err <= 1'b0;
`else
  assign word = asm_d;
  assign parity_err = 1'b0;
`endif
  // beat counter, assembly register and bit order latched at beat 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      asm_q <= '0;
      order_q <= 1'b0;
    end else begin
      cnt <= (!en || done) ? '0 : cnt + 1'b1;
      asm_q <= asm_d;
      order_q <= ord;
    end
  // output holding register with handshake and sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      parallel_data <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load) parallel_data <= word;
      out_valid <= load | (out_valid & ~out_ready);
      overflow <= (done & ~load) | (overflow & ~ovf_clr);
    end
endmodule

// File: tb/tb_multi_lane_deserializer.sv
// tb_multi_lane_deserializer: directed checks of a 1-lane and a 4-lane deserializer
module tb_multi_lane_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sd1 = 1'b0, en1 = 1'b0, msb1 = 1'b0, rdy1 = 1'b0, clr1 = 1'b0;
  logic [15:0] pd1;
  logic v1, o1, pe1;
  logic [3:0] sd4 = 4'h0;
  logic en4 = 1'b0, msb4 = 1'b0, rdy4 = 1'b0, clr4 = 1'b0;
  logic [15:0] pd4;
  logic v4, o4, pe4;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_lane_deserializer #(.FETCH_WIDTH(16), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .serial_data(sd1), .en(en1), .msb_first(msb1),
    .out_ready(rdy1), .ovf_clr(clr1), .parallel_data(pd1), .out_valid(v1),
    .overflow(o1), .parity_err(pe1)
  );

  multi_lane_deserializer #(.FETCH_WIDTH(16), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .serial_data(sd4), .en(en4), .msb_first(msb4),
    .out_ready(rdy4), .ovf_clr(clr4), .parallel_data(pd4), .out_valid(v4),
    .overflow(o4), .parity_err(pe4)
  );

  task automatic send1(input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      en1 = 1'b1;
      msb1 = 1'b0;
      sd1 = w[4'(k)];
    end
`ifdef DESER_PARITY_EN
    @(negedge clk);
    sd1 = ^w;
`endif
  endtask

  task automatic word4(input logic [15:0] beats, input logic msb, input logic tog, input logic [3:0] par);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en4 = 1'b1;
      if (k == 0) msb4 = msb;
      else if (k == 2 && tog) msb4 = ~msb;
      sd4 = 4'(beats >> (4 * k));
    end
`ifdef DESER_PARITY_EN
    @(negedge clk);
    sd4 = par;
`else
    sd4 = sd4 | (par & 4'h0);
`endif
  endtask

  task automatic idle();
    @(negedge clk);
    en1 = 1'b0;
    en4 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (pd1 !== 16'h0) begin n_bad++; $display("FAIL reset_pd1 got %h want 0000", pd1); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL reset_v1 got %b want 0", v1); end
    n_cmp++; if (o1 !== 1'b0) begin n_bad++; $display("FAIL reset_o1 got %b want 0", o1); end
    n_cmp++; if (pe1 !== 1'b0) begin n_bad++; $display("FAIL reset_pe1 got %b want 0", pe1); end
    n_cmp++; if (pd4 !== 16'h0 || v4 !== 1'b0) begin n_bad++; $display("FAIL reset_dut4 got %h/%b want 0000/0", pd4, v4); end
    rst = 1'b0;
  endtask

  task automatic test_lsb_single();
    rdy1 = 1'b1;
    send1(16'hA5C3);
    idle();
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL lsb_valid got %b want 1", v1); end
    n_cmp++; if (pd1 !== 16'hA5C3) begin n_bad++; $display("FAIL lsb_data got %h want a5c3", pd1); end
    n_cmp++; if (pe1 !== 1'b0) begin n_bad++; $display("FAIL lsb_parity got %b want 0", pe1); end
    idle();
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL lsb_one_cycle got %b want 0", v1); end
  endtask

  task automatic test_msb_lanes();
    rdy4 = 1'b1;
    word4(16'h4321, 1'b1, 1'b0, 4'h4);
    idle();
    n_cmp++; if (pd4 !== 16'h84C2 || v4 !== 1'b1) begin n_bad++; $display("FAIL msb4_data got %h/%b want 84c2/1", pd4, v4); end
    word4(16'h4321, 1'b1, 1'b1, 4'h4);
    idle();
    n_cmp++; if (pd4 !== 16'h84C2 || v4 !== 1'b1) begin n_bad++; $display("FAIL msb4_toggle got %h/%b want 84c2/1", pd4, v4); end
    word4(16'h4321, 1'b0, 1'b1, 4'h4);
    idle();
    n_cmp++; if (pd4 !== 16'h4321 || v4 !== 1'b1) begin n_bad++; $display("FAIL lsb4_toggle got %h/%b want 4321/1", pd4, v4); end
    idle();
  endtask

  task automatic test_overflow();
    rdy1 = 1'b0;
    send1(16'h1111);
    send1(16'h2222);
    idle();
    n_cmp++; if (pd1 !== 16'h1111 || v1 !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got %h/%b want 1111/1", pd1, v1); end
    n_cmp++; if (o1 !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", o1); end
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    n_cmp++; if (o1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", o1); end
    n_cmp++; if (pd1 !== 16'h1111 || v1 !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_hold got %h/%b want 1111/1", pd1, v1); end
  endtask

  task automatic test_same_edge();
    send1(16'h2222);
    rdy1 = 1'b1;
    idle();
    n_cmp++; if (v1 !== 1'b1 || pd1 !== 16'h2222) begin n_bad++; $display("FAIL same_edge got %h/%b want 2222/1", pd1, v1); end
    n_cmp++; if (o1 !== 1'b0) begin n_bad++; $display("FAIL same_edge_ovf got %b want 0", o1); end
    idle();
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL same_edge_drain got %b want 0", v1); end
    rdy1 = 1'b0;
    send1(16'h3333);
    send1(16'h4444);
    clr1 = 1'b1;
    idle();
    clr1 = 1'b0;
    n_cmp++; if (o1 !== 1'b1 || pd1 !== 16'h3333) begin n_bad++; $display("FAIL set_wins got %b/%h want 1/3333", o1, pd1); end
    rdy1 = 1'b1;
    idle();
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL set_wins_drain got %b want 0", v1); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en1 = 1'b1;
      sd1 = 1'b1;
    end
    idle();
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL abort_novalid got %b want 0", v1); end
    send1(16'h00FF);
    idle();
    n_cmp++; if (pd1 !== 16'h00FF || v1 !== 1'b1) begin n_bad++; $display("FAIL abort_data got %h/%b want 00ff/1", pd1, v1); end
    idle();
  endtask

  task automatic test_async_reset();
    rdy1 = 1'b0;
    send1(16'h1234);
    send1(16'h5678);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en1 = 1'b1;
      sd1 = 1'b1;
    end
    n_cmp++; if (o1 !== 1'b1 || v1 !== 1'b1) begin n_bad++; $display("FAIL pre_rst got %b/%b want 1/1", o1, v1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pd1 !== 16'h0 || v1 !== 1'b0 || o1 !== 1'b0 || pe1 !== 1'b0) begin n_bad++; $display("FAIL async_rst got %h/%b/%b/%b want 0000/0/0/0", pd1, v1, o1, pe1); end
    @(negedge clk);
    rst = 1'b0;
    en1 = 1'b0;
    rdy1 = 1'b1;
    send1(16'h0F0F);
    idle();
    n_cmp++; if (pd1 !== 16'h0F0F || v1 !== 1'b1) begin n_bad++; $display("FAIL post_rst got %h/%b want 0f0f/1", pd1, v1); end
    idle();
  endtask

  task automatic test_parity();
    rdy4 = 1'b1;
    word4(16'h0003, 1'b0, 1'b0, 4'h2);
    idle();
`ifdef DESER_PARITY_EN
    n_cmp++; if (pe4 !== 1'b1 || v4 !== 1'b1 || pd4 !== 16'h0003) begin n_bad++; $display("FAIL par_bad got %b/%b/%h want 1/1/0003", pe4, v4, pd4); end
    idle();
    n_cmp++; if (pe4 !== 1'b0 || v4 !== 1'b0) begin n_bad++; $display("FAIL par_xfer_clr got %b/%b want 0/0", pe4, v4); end
    word4(16'h0003, 1'b0, 1'b0, 4'h3);
    idle();
    n_cmp++; if (pe4 !== 1'b0 || v4 !== 1'b1 || pd4 !== 16'h0003) begin n_bad++; $display("FAIL par_good got %b/%b/%h want 0/1/0003", pe4, v4, pd4); end
`else
    n_cmp++; if (pe4 !== 1'b0 || v4 !== 1'b1 || pd4 !== 16'h0003) begin n_bad++; $display("FAIL par_tied got %b/%b/%h want 0/1/0003", pe4, v4, pd4); end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_lanes();
    test_overflow();
    test_same_edge();
    test_abort();
    test_async_reset();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
